usb_rx_decoder: RTL

//  Receive-side partner of the USB transmit writer: samples the 2-bit differential line pair
//  {D+,D-} once per bit strobe, locks onto SYNC (KJKJKJKK), NRZI-decodes the payload LSB-first

---
 rtl/usb_rx_decoder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder
//   Receive side of the USB line: samples {D+,D-} on each bit strobe, locks
//   onto SYNC (KJKJKJKK), NRZI-decodes the payload LSB-first into rx_data and
//   closes the packet on an SE0 EOP followed by J.
//
//   Optional feature: define USB_RX_BITSTUFF_EN to remove stuffed bits (the
//   symbol after six consecutive decoded 1s must be a transition and is
//   dropped). Without it every J/K symbol in DATA is a payload bit.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   shift     in   bit strobe; d_in is only looked at when shift=1
//   d_in      in   {D+,D-}: 10=J 01=K 00=SE0 11=SE1
//   rx_data   out  decoded payload, bit i = i-th received bit
//   rx_len    out  number of payload bits in rx_data
//   rx_valid  out  1-cycle pulse, packet complete
//   rx_err    out  1-cycle pulse, packet aborted
//   err_code  out  01 SYNC mismatch, 10 line/EOP error, 11 overflow (held)
//   rx_busy   out  1 whenever the receiver is not idle
module usb_rx_decoder #(
  parameter int PKT_MAX_BITS = 88,
  parameter int MIN_EOP_SE0  = 2,
  parameter int IDLE_J_COUNT = 8,
  localparam int LEN_W = $clog2(PKT_MAX_BITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift,
  input  logic [1:0]              d_in,
  output logic [PKT_MAX_BITS-1:0] rx_data,
  output logic [LEN_W-1:0]        rx_len,
  output logic                    rx_valid,
  output logic                    rx_err,
  output logic [1:0]              err_code,
  output logic                    rx_busy
);

  localparam int SE0_W = $clog2(MIN_EOP_SE0 + 1);
  localparam int JC_W  = $clog2(IDLE_J_COUNT + 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, RECOVER} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              sym_idx_q, sym_idx_d;
  logic                    prev_j_q, prev_j_d;
  logic [LEN_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SE0_W-1:0]        se0_cnt_q, se0_cnt_d;
  logic [JC_W-1:0]         j_cnt_q, j_cnt_d;
  logic [PKT_MAX_BITS-1:0] rx_data_q, rx_data_d;
  logic [LEN_W-1:0]        rx_len_q, rx_len_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rx_err_q, rx_err_d;
  logic [1:0]              err_code_q, err_code_d;
  logic                    rx_busy_q, rx_busy_d;
`ifdef USB_RX_BITSTUFF_EN
  logic [2:0]              run_q, run_d;
`endif

  logic is_j, is_k, is_se0, is_se1, exp_j, sync_ok, nrzi_bit;

  assign is_j   = (d_in == 2'b10);
  assign is_k   = (d_in == 2'b01);
  assign is_se0 = (d_in == 2'b00);
  assign is_se1 = (d_in == 2'b11);
  // SYNC pattern KJKJKJKK: odd positions 1,3,5 are J, the rest K.
  assign exp_j    = sym_idx_q[0] && (sym_idx_q != 3'd7);
  assign sync_ok  = exp_j ? is_j : is_k;
  // NRZI: no transition decodes to 1.
  assign nrzi_bit = (is_j == prev_j_q);

  always_comb begin
    state_d    = state_q;
    sym_idx_d  = sym_idx_q;
    prev_j_d   = prev_j_q;
    bit_cnt_d  = bit_cnt_q;
    se0_cnt_d  = se0_cnt_q;
    j_cnt_d    = j_cnt_q;
    rx_data_d  = rx_data_q;
    rx_len_d   = rx_len_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    err_code_d = err_code_q;
`ifdef USB_RX_BITSTUFF_EN
    run_d      = run_q;
`endif
    if (shift) begin
      case (state_q)
        IDLE: begin
          if (is_k) begin
            state_d   = SYNC;
            sym_idx_d = 3'd1;
            rx_data_d = '0;
            rx_len_d  = '0;
          end
        end
        SYNC: begin
          if (!sync_ok) begin
            rx_err_d   = 1'b1;
            err_code_d = 2'b01;
            state_d    = RECOVER;
            j_cnt_d    = '0;
          end else if (sym_idx_q == 3'd7) begin
            state_d   = DATA;
            prev_j_d  = 1'b0;
            bit_cnt_d = '0;
`ifdef USB_RX_BITSTUFF_EN
            run_d     = '0;
`endif
          end else begin
            sym_idx_d = sym_idx_q + 3'd1;
          end
        end
        DATA: begin
          if (is_se0) begin
            state_d   = EOP;
            se0_cnt_d = SE0_W'(1);
          end else if (is_se1) begin
            rx_err_d   = 1'b1;
            err_code_d = 2'b10;
            state_d    = RECOVER;
            j_cnt_d    = '0;
`ifdef USB_RX_BITSTUFF_EN
          end else if (run_q == 3'd6) begin
            // Stuffed position: must be a transition, never stored.
            if (nrzi_bit) begin
              rx_err_d   = 1'b1;
              err_code_d = 2'b10;
              state_d    = RECOVER;
              j_cnt_d    = '0;
            end else begin
              run_d    = '0;
              prev_j_d = is_j;
            end
`endif
          end else if (bit_cnt_q == LEN_W'(PKT_MAX_BITS)) begin
            rx_err_d   = 1'b1;
            err_code_d = 2'b11;
            state_d    = RECOVER;
            j_cnt_d    = '0;
          end else begin
            rx_data_d[bit_cnt_q] = nrzi_bit;
            bit_cnt_d = bit_cnt_q + LEN_W'(1);
            prev_j_d  = is_j;
`ifdef USB_RX_BITSTUFF_EN
            run_d     = nrzi_bit ? run_q + 3'd1 : 3'd0;
`endif
          end
        end
        EOP: begin
          if (is_se0) begin
            if (se0_cnt_q < SE0_W'(MIN_EOP_SE0)) se0_cnt_d = se0_cnt_q + SE0_W'(1);
          end else if (is_j) begin
            state_d = IDLE;
            if (se0_cnt_q >= SE0_W'(MIN_EOP_SE0) && bit_cnt_q != '0) begin
              rx_valid_d = 1'b1;
              rx_len_d   = bit_cnt_q;
            end else begin
              rx_err_d   = 1'b1;
              err_code_d = 2'b10;
            end
          end else begin
            rx_err_d   = 1'b1;
            err_code_d = 2'b10;
            state_d    = RECOVER;
            j_cnt_d    = '0;
          end
        end
        RECOVER: begin
          if (!is_j) begin
            j_cnt_d = '0;
          end else if (j_cnt_q == JC_W'(IDLE_J_COUNT - 1)) begin
            j_cnt_d = '0;
            state_d = IDLE;
          end else begin
            j_cnt_d = j_cnt_q + JC_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sym_idx_q  <= '0;
      prev_j_q   <= 1'b0;
      bit_cnt_q  <= '0;
      se0_cnt_q  <= '0;
      j_cnt_q    <= '0;
      rx_data_q  <= '0;
      rx_len_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      err_code_q <= 2'b00;
      rx_busy_q  <= 1'b0;
`ifdef USB_RX_BITSTUFF_EN
      run_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sym_idx_q  <= sym_idx_d;
      prev_j_q   <= prev_j_d;
      bit_cnt_q  <= bit_cnt_d;
      se0_cnt_q  <= se0_cnt_d;
      j_cnt_q    <= j_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_len_q   <= rx_len_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      err_code_q <= err_code_d;
      rx_busy_q  <= rx_busy_d;
`ifdef USB_RX_BITSTUFF_EN
      run_q      <= run_d;
`endif
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_len   = rx_len_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign err_code = err_code_q;
  assign rx_busy  = rx_busy_q;

endmodule
